// File: rtl/imem_loader.sv
// Instruction-memory loader: packs a little-endian byte stream into 32-bit words,
// writes them to sequential word addresses and holds the core in reset until done.
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   len_words,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

    localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

    state_t                r_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_word_cnt;
    logic [1:0]            r_byte_cnt;
    logic [7:0]            r_lane [3];
    logic                  r_s_ready;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]           r_mem_wdata;
    logic                  r_cpu_rst_n;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_hs;
    logic                  w_len_ok;
    logic [ADDR_WIDTH:0]   w_word_cnt_inc;

    assign w_hs           = s_valid & r_s_ready;
    assign w_len_ok       = (len_words != '0) && (len_words <= LEN_MAX);
    assign w_word_cnt_inc = r_word_cnt + {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Lanes 0..2 are buffered; lane 3 goes straight into the write word.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_lane
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_lane[gi] <= 8'h00;
                end else if (w_hs && (r_byte_cnt == 2'(gi))) begin
                    r_lane[gi] <= s_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_word_cnt  <= '0;
            r_byte_cnt  <= 2'd0;
            r_s_ready   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_len_ok) begin
                            r_len       <= len_words;
                            r_word_cnt  <= '0;
                            r_byte_cnt  <= 2'd0;
                            r_err       <= 1'b0;
                            r_cpu_rst_n <= 1'b0;
                            r_busy      <= 1'b1;
                            r_s_ready   <= 1'b1;
                            r_state     <= S_RECV;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_RECV: begin
                    if (w_hs) begin
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_wdata <= {s_data, r_lane[2], r_lane[1], r_lane[0]};
                            r_mem_addr  <= r_word_cnt[ADDR_WIDTH-1:0];
                            r_mem_we    <= 1'b1;
                            r_s_ready   <= 1'b0;
                            r_state     <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    r_mem_we   <= 1'b0;
                    r_word_cnt <= w_word_cnt_inc;
                    if (w_word_cnt_inc == r_len) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_s_ready <= 1'b1;
                        r_state   <= S_RECV;
                    end
                end
                S_DONE: begin
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cpu_rst_n <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign s_ready   = r_s_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rst_n = r_cpu_rst_n;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: random byte streams, expected writes queued from the byte
// list and checked by an independent monitor whenever mem_we is seen.
module tb_imem_loader;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   len_words;
    logic          s_valid;
    logic [7:0]    s_data;
    logic          s_ready;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          cpu_rst_n;
    logic          busy;
    logic          done;
    logic          err;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .len_words(len_words),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .err(err)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] bq[$];
    int         tests = 0;
    int         fails = 0;
    int         we_count = 0;
    int         done_count = 0;
    logic       prev_we = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // Monitor: pops one expected write per mem_we cycle.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_we = 1'b0;
            end else begin
                if (mem_we) begin
                    we_count++;
                    check("s_ready_in_write", 32'(s_ready), 32'd0);
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_write: got addr %0d data 0x%08h, required no write",
                                 mem_addr, mem_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", 32'(mem_addr), 32'(e.addr));
                        check("wr_data", mem_wdata, e.data);
                    end
                end
                if (done) begin
                    done_count++;
                    check("done_after_write", 32'(prev_we), 32'd1);
                    check("cpu_rst_n_low_in_done", 32'(cpu_rst_n), 32'd0);
                end
                prev_we = mem_we;
            end
        end
    end

    // Reference: word k is bytes 4k..4k+3, little-endian, at address k.
    task automatic expect_load(input int nwords);
        wr_t w;
        for (int k = 0; k < nwords; k++) begin
            w.addr = AW'(k);
            w.data = {bq[4*k+3], bq[4*k+2], bq[4*k+1], bq[4*k]};
            exp_q.push_back(w);
        end
    endtask

    task automatic do_start(input int len);
        start = 1'b1;
        len_words = (AW+1)'(len);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_bytes(input int n, input bit gapped, input int start_at);
        int g;
        bit ok;
        for (int i = 0; i < n; i++) begin
            if (gapped) begin
                g = $urandom_range(0, 3);
                repeat (g) begin
                    s_valid = 1'b0;
                    s_data = 8'($urandom);
                    @(posedge clk); #1;
                end
            end
            if (i == start_at) begin
                start = 1'b1;
                len_words = (AW+1)'(1);
            end
            s_valid = 1'b1;
            s_data = bq[i];
            ok = 1'b0;
            for (int c = 0; c < 50 && !ok; c++) begin
                @(negedge clk);
                ok = s_ready;
                @(posedge clk); #1;
            end
            if (!ok) begin
                tests++;
                fails++;
                $display("FAIL byte_accept_timeout: byte %0d not accepted, required handshake", i);
                s_valid = 1'b0;
                return;
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done in %0d cycles, required done", budget);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
    endtask

    task automatic run_load(input int len, input bit gapped);
        int we0, dn0;
        we0 = we_count;
        dn0 = done_count;
        expect_load(len);
        do_start(len);
        check("busy_after_start", 32'(busy), 32'd1);
        check("err_after_good_start", 32'(err), 32'd0);
        send_bytes(4 * len, gapped, -1);
        wait_done(50);
        @(negedge clk);
        check("cpu_rst_n_after_done", 32'(cpu_rst_n), 32'd1);
        check("busy_after_done", 32'(busy), 32'd0);
        check("done_one_cycle", 32'(done), 32'd0);
        check("write_count", 32'(we_count - we0), 32'(len));
        check("done_count", 32'(done_count - dn0), 32'd1);
        $display("[TB] load len=%0d gapped=%0d: %0d writes, %0d done", len, gapped,
                 we_count - we0, done_count - dn0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int we0, dn0, len;
        rst = 1'b1;
        start = 1'b0;
        len_words = '0;
        s_valid = 1'b0;
        s_data = 8'h00;

        // Reset with random inputs
        repeat (2) begin
            start = 1'($urandom);
            len_words = (AW+1)'($urandom);
            s_valid = 1'($urandom);
            s_data = 8'($urandom);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        start = 1'b0;
        rst = 1'b0;
        s_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_s_ready", 32'(s_ready), 32'd0);
        end
        s_valid = 1'b0;
        @(posedge clk); #1;

        // Two-word load, back-to-back then gapped
        bq = '{8'h93, 8'h04, 8'h40, 8'h00, 8'h13, 8'h03, 8'hC4, 8'hFF};
        run_load(2, 1'b0);
        run_load(2, 1'b1);

        // Length errors
        do_start(0);
        @(negedge clk);
        check("len0_err", 32'(err), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        @(posedge clk); #1;
        do_start(65);
        @(negedge clk);
        check("len65_err", 32'(err), 32'd1);
        check("len65_busy", 32'(busy), 32'd0);
        check("len65_cpu_rst_n", 32'(cpu_rst_n), 32'd1);
        @(posedge clk); #1;
        bq.delete();
        for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
        run_load(1, 1'b0);

        // start held from mid-load through the DONE cycle
        bq.delete();
        for (int i = 0; i < 12; i++) bq.push_back(8'($urandom));
        we0 = we_count;
        dn0 = done_count;
        expect_load(3);
        do_start(3);
        send_bytes(12, 1'b1, 5);
        wait_done(50);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        check("start_in_done_ignored", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        check("interfere_writes", 32'(we_count - we0), 32'd3);
        check("interfere_done", 32'(done_count - dn0), 32'd1);
        $display("[TB] interference load: %0d writes", we_count - we0);

        // Reset after two bytes of word 0
        @(posedge clk); #1;
        bq.delete();
        for (int i = 0; i < 8; i++) bq.push_back(8'($urandom));
        expect_load(2);
        do_start(2);
        send_bytes(2, 1'b0, -1);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check_reset_outputs();
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        bq = '{8'h13, 8'h00, 8'h00, 8'h00};
        run_load(1, 1'b0);

        // Random loads
        repeat (3) begin
            len = $urandom_range(1, 6);
            bq.delete();
            for (int i = 0; i < 4 * len; i++) bq.push_back(8'($urandom));
            run_load(len, 1'($urandom_range(0, 1)));
        end

        // Full depth
        bq.delete();
        for (int i = 0; i < 256; i++) bq.push_back(8'(i));
        run_load(64, 1'b0);

        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory interface. The single-cycle core reads instruction memory; this block fills it.
- Accepts a byte stream over a valid/ready handshake and packs 4 bytes little-endian into 32-bit words.
- Writes each word to sequential instruction-memory word addresses starting at 0.
- Holds the core in reset for the whole load and releases it once the last word is written.

Parameters:
- ADDR_WIDTH, 6, word-address width of instruction memory. Depth = 2^ADDR_WIDTH words.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load; sampled in IDLE only.
- len_words  input  ADDR_WIDTH+1  number of words to load; sampled with start.
- s_valid  input  1  byte-stream valid.
- s_data  input  8  byte-stream data.
- s_ready  output  1  byte-stream ready.
- mem_we  output  1  instruction-memory write enable, one cycle per word.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  write data.
- cpu_rst_n  output  1  core reset, active-low (0 holds the core in reset).
- busy  output  1  high from the cycle after an accepted start until the DONE cycle, inclusive.
- done  output  1  one-cycle pulse when the load completes.
- err  output  1  sticky flag for a rejected length.

Behaviour:
- Reset values: state IDLE; s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst_n=0, busy=0, done=0, err=0; byte and word counters = 0.
- rst overrides all other inputs.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - s_ready=0; s_valid is ignored and no byte is consumed.
  - start with 1 <= len_words <= 2^ADDR_WIDTH: latch len, clear counters, clear err, cpu_rst_n<=0, busy<=1, go to RECV.
  - start with len_words=0 or len_words > 2^ADDR_WIDTH: err<=1, stay in IDLE, no writes, cpu_rst_n unchanged.
- RECV:
  - s_ready=1. Handshake = s_valid & s_ready.
  - Each handshake stores s_data into lane byte_cnt (lane 0 = bits 7:0, lane 3 = bits 31:24) and increments byte_cnt mod 4.
  - A cycle with no handshake changes nothing.
  - On the handshake for lane 3: mem_wdata<=assembled word (including the current byte), mem_addr<=word_cnt, mem_we<=1, go to WRITE.
- WRITE (exactly one cycle):
  - mem_we=1, s_ready=0.
  - mem_we<=0 and word_cnt<=word_cnt+1.
  - If word_cnt+1 == len, go to DONE; otherwise go to RECV.
  - Sustained rate: at most 1 word per 5 cycles.
- DONE (one cycle):
  - done=1; busy<=0, cpu_rst_n<=1; go to IDLE.
  - cpu_rst_n stays 1 until the next accepted start.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Addresses never wrap: the maximum length ends at address 2^ADDR_WIDTH-1.
- start outside IDLE is ignored, including in the DONE cycle.
- Reset mid-load:
  - Outputs and counters return to reset values and cpu_rst_n goes to 0.
  - Words already written stay in memory.
  - A partially assembled word is discarded; the next load starts at address 0, lane 0.
- A rejected start after a completed load leaves cpu_rst_n=1 and memory untouched.

Test Plan:
- Reset: assert rst 2 cycles with random inputs -> all outputs at reset values. s_valid high in IDLE -> s_ready stays 0.
- Two-word load, back-to-back valid:
  - Stimulus: start, len=2, bytes 93 04 40 00 13 03 C4 FF.
  - Required: mem_we pulse with addr 0 / data 0x00400493, then addr 1 / data 0xFFC40313.
  - Required: done one cycle after the second write; cpu_rst_n rises with done's falling edge; exactly 2 mem_we cycles.
- Gapped stream:
  - Stimulus: same bytes, s_valid toggled pseudo-randomly.
  - Required: identical writes and data; bytes consumed only on handshake; s_ready=0 in every WRITE cycle.
- Length errors (ADDR_WIDTH=6):
  - len=0 -> err=1, busy=0, no mem_we.
  - len=65 -> same as len=0.
  - Following start with len=1 -> err clears and the load proceeds.
- Interference:
  - start pulsed mid-load -> ignored, total writes equal the latched len.
  - rst after 2 bytes of word 0, then a new len=1 load of bytes 13 00 00 00 -> single write at addr 0 with data 0x00000013.
- Full depth: len=64, incrementing bytes -> addresses 0..63 in order, word k = {4k+3,4k+2,4k+1,4k}, no address 64, done once.
